lru_victim_sel: RTL

//  Read-side companion of the 8192-set x 3b tree-PLRU regfile for the 4-way 1MB L1.

---
 rtl/lru_victim_sel_if.sv | 41 ++++
 rtl/lru_victim_sel.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lru_victim_sel_if.sv
// -----------------------------------------------------------------------------
// lru_victim_sel_if
// Bundles the fill-request, victim-response and PLRU-regfile signals of
// lru_victim_sel.
//   req_valid/req_ready/req_set/req_way_vld  : fill request from miss controller
//   rsp_valid/rsp_ready/rsp_set/rsp_way/
//   rsp_plru_hit                             : victim response to miss controller
//   lru_ra/lru_rd                            : regfile combinational read port
//   lru_wa/lru_way_sel/lru_wr                : regfile MRU update port
// Modports: master = controller + regfile side, slave = lru_victim_sel.
// -----------------------------------------------------------------------------
interface lru_victim_sel_if #(
   parameter int SET_AW = 13
);
   logic              req_valid;
   logic              req_ready;
   logic [SET_AW-1:0] req_set;
   logic [3:0]        req_way_vld;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [SET_AW-1:0] rsp_set;
   logic [3:0]        rsp_way;
   logic              rsp_plru_hit;
   logic [SET_AW-1:0] lru_ra;
   logic [2:0]        lru_rd;
   logic [SET_AW-1:0] lru_wa;
   logic [3:0]        lru_way_sel;
   logic              lru_wr;

   modport master (
      output req_valid, req_set, req_way_vld, rsp_ready, lru_rd,
      input  req_ready, rsp_valid, rsp_set, rsp_way, rsp_plru_hit,
             lru_ra, lru_wa, lru_way_sel, lru_wr
   );

   modport slave (
      input  req_valid, req_set, req_way_vld, rsp_ready, lru_rd,
      output req_ready, rsp_valid, rsp_set, rsp_way, rsp_plru_hit,
             lru_ra, lru_wa, lru_way_sel, lru_wr
   );
endinterface

// File: rtl/lru_victim_sel.sv
// -----------------------------------------------------------------------------
// lru_victim_sel
// Read-side companion of the tree-PLRU regfile for a 4-way L1. Accepts a fill
// request, reads the set's PLRU bits, returns a one-hot victim over a
// valid/ready handshake, then writes the victim back to the regfile as MRU.
//   clk    : clock
//   reset  : synchronous, active-high reset
//   bus    : lru_victim_sel_if.slave (request, response and regfile ports)
// Optional feature macro: VICTIM_INVALID_FIRST_EN -- when defined, an invalid
// way (lowest index) is preferred over the PLRU decode.
// Simulation-only macro: SIM -- enables the unknown-lru_rd checker.
// FSM: IDLE -> LOOKUP -> RESP -> UPDATE -> IDLE (4 cycles per request).
// -----------------------------------------------------------------------------

`ifdef SIM
// Flags an unknown PLRU read while the block is sampling it.
module lru_victim_sel_chk (
   input logic       clk,
   input logic       reset,
   input logic       lookup,
   input logic [2:0] rd
);
   a_rd_known: assert property (@(posedge clk) disable iff (reset) lookup |-> !$isunknown(rd))
      else $error("lru_victim_sel: unknown lru_rd in LOOKUP");
endmodule
`endif

module lru_victim_sel #(
   parameter int SET_AW = 13,
   parameter int WAYS   = 4,
   parameter int LRU_W  = 3
) (
   input logic           clk,
   input logic           reset,
   lru_victim_sel_if.slave bus
);

   generate
      if (WAYS != 4 || LRU_W != 3) begin : g_param_err
         $error("lru_victim_sel supports only WAYS=4, LRU_W=3");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOOKUP = 2'd1,
      RESP   = 2'd2,
      UPDATE = 2'd3
   } state_t;

   // Inverse of the regfile update rule. Unlisted (unknown) codes fall to way0.
   function automatic logic [3:0] plru_decode(input logic [2:0] rd);
      logic [3:0] way;
      case (rd)
         3'b000:  way = 4'b1000;
         3'b001:  way = 4'b1000;
         3'b010:  way = 4'b0100;
         3'b011:  way = 4'b0100;
         3'b100:  way = 4'b0010;
         3'b110:  way = 4'b0010;
         3'b101:  way = 4'b0001;
         3'b111:  way = 4'b0001;
         default: way = 4'b0001;
      endcase
      return way;
   endfunction

   state_t            state_r, next_state_s;
   logic [SET_AW-1:0] set_r;
   logic              accept_s;
   logic [3:0]        victim_s;
   logic              hit_s;

   logic              req_ready_r,  req_ready_d_s;
   logic              rsp_valid_r,  rsp_valid_d_s;
   logic [SET_AW-1:0] rsp_set_r,    rsp_set_d_s;
   logic [3:0]        rsp_way_r,    rsp_way_d_s;
   logic              rsp_hit_r,    rsp_hit_d_s;
   logic [SET_AW-1:0] lru_ra_r,     lru_ra_d_s;
   logic [SET_AW-1:0] lru_wa_r,     lru_wa_d_s;
   logic [3:0]        way_sel_r,    way_sel_d_s;
   logic              wr_r,         wr_d_s;

   assign accept_s = bus.req_valid & req_ready_r;

`ifdef VICTIM_INVALID_FIRST_EN
   logic [3:0] vld_r;

   // Lowest-index invalid way; only called when at least one way is invalid.
   function automatic logic [3:0] first_invalid(input logic [3:0] vld);
      logic [3:0] way;
      if (!vld[0]) begin
         way = 4'b0001;
      end else if (!vld[1]) begin
         way = 4'b0010;
      end else if (!vld[2]) begin
         way = 4'b0100;
      end else begin
         way = 4'b1000;
      end
      return way;
   endfunction

   // Captures the request's line-valid bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_r <= 4'b0000;
      end else if (accept_s) begin
         vld_r <= bus.req_way_vld;
      end
   end

   // Victim choice: invalid way first, PLRU decode when the set is full.
   always_comb begin
      if (vld_r != 4'b1111) begin
         victim_s = first_invalid(vld_r);
         hit_s    = 1'b0;
      end else begin
         victim_s = plru_decode(bus.lru_rd);
         hit_s    = 1'b1;
      end
   end
`else
   // Victim choice: PLRU decode only.
   always_comb begin
      victim_s = plru_decode(bus.lru_rd);
      hit_s    = 1'b1;
   end
`endif

   // State, captured set and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         set_r       <= '0;
         req_ready_r <= 1'b0;
         rsp_valid_r <= 1'b0;
         rsp_set_r   <= '0;
         rsp_way_r   <= 4'b0000;
         rsp_hit_r   <= 1'b0;
         lru_ra_r    <= '0;
         lru_wa_r    <= '0;
         way_sel_r   <= 4'b0000;
         wr_r        <= 1'b0;
      end else begin
         state_r     <= next_state_s;
         set_r       <= accept_s ? bus.req_set : set_r;
         req_ready_r <= req_ready_d_s;
         rsp_valid_r <= rsp_valid_d_s;
         rsp_set_r   <= rsp_set_d_s;
         rsp_way_r   <= rsp_way_d_s;
         rsp_hit_r   <= rsp_hit_d_s;
         lru_ra_r    <= lru_ra_d_s;
         lru_wa_r    <= lru_wa_d_s;
         way_sel_r   <= way_sel_d_s;
         wr_r        <= wr_d_s;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               next_state_s = LOOKUP;
            end else begin
               next_state_s = IDLE;
            end
         end
         LOOKUP: next_state_s = RESP;
         RESP: begin
            if (bus.rsp_ready) begin
               next_state_s = UPDATE;
            end else begin
               next_state_s = RESP;
            end
         end
         UPDATE:  next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // Next values of the registered outputs.
   always_comb begin
      req_ready_d_s = (next_state_s == IDLE);
      rsp_valid_d_s = rsp_valid_r;
      rsp_set_d_s   = rsp_set_r;
      rsp_way_d_s   = rsp_way_r;
      rsp_hit_d_s   = rsp_hit_r;
      lru_ra_d_s    = lru_ra_r;
      lru_wa_d_s    = lru_wa_r;
      way_sel_d_s   = 4'b0000;
      wr_d_s        = 1'b0;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               lru_ra_d_s = bus.req_set;
            end else begin
               lru_ra_d_s = lru_ra_r;
            end
         end
         LOOKUP: begin
            rsp_valid_d_s = 1'b1;
            rsp_set_d_s   = set_r;
            rsp_way_d_s   = victim_s;
            rsp_hit_d_s   = hit_s;
         end
         RESP: begin
            if (bus.rsp_ready) begin
               // The regfile builds write data from the rd of ra, so ra tracks wa.
               rsp_valid_d_s = 1'b0;
               wr_d_s        = 1'b1;
               lru_wa_d_s    = set_r;
               lru_ra_d_s    = set_r;
               way_sel_d_s   = rsp_way_r;
            end else begin
               rsp_valid_d_s = 1'b1;
            end
         end
         UPDATE: begin
            wr_d_s      = 1'b0;
            way_sel_d_s = 4'b0000;
         end
         default: begin
            rsp_valid_d_s = 1'b0;
         end
      endcase
   end

   assign bus.req_ready    = req_ready_r;
   assign bus.rsp_valid    = rsp_valid_r;
   assign bus.rsp_set      = rsp_set_r;
   assign bus.rsp_way      = rsp_way_r;
   assign bus.rsp_plru_hit = rsp_hit_r;
   assign bus.lru_ra       = lru_ra_r;
   assign bus.lru_wa       = lru_wa_r;
   // Reset arriving in UPDATE must suppress the write already registered.
   assign bus.lru_wr       = wr_r & ~reset;
   assign bus.lru_way_sel  = way_sel_r & {4{~reset}};

`ifdef SIM
   lru_victim_sel_chk u_chk (
      .clk    (clk),
      .reset  (reset),
      .lookup (state_r == LOOKUP),
      .rd     (bus.lru_rd)
   );
`endif

endmodule
